add_num_seq: RTL and testbench
==============================

# add_num_seq

Sequencer for the add-numbers AFU datapath. It walks a buffer of `num_lines` cache lines in host memory. For each line it issues one CCI-P c0 read, extracts two 8-bit operands, adds them, and issues one c1 write of the sum to a destination buffer, waiting for the write ack before moving to the next line. It sits between the MMIO CSR block, which supplies start, addresses and count, and the host CCI-P channel mux.

## Interface
Parameters:
- `OPA_LSB`, 8: bit offset of operand A in the read line.
- `OPB_LSB`, 16: bit offset of operand B in the read line.
- `TIMEOUT_CYCLES`, 4096: response timeout, used only with `ADD_NUM_SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  launch pulse; honoured only in IDLE.
- `src_addr`  in  42  source cache-line address, sampled on accepted start.
- `dst_addr`  in  42  destination cache-line address, sampled on accepted start.
- `num_lines`  in  16  line count, sampled on accepted start.
- `busy`  out  1  high from the cycle after an accepted start until the cycle of `done`.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky timeout flag; cleared on the next accepted start.
- `lines_done`  out  16  count of acked writes in the current job.
- `c0_req_valid`  out  1  read request strobe.
- `c0_req_addr`  out  42  read address.
- `c0_req_mdata`  out  16  read tag (equal to the line index).
- `c0_alm_full`  in  1  c0 TX almost-full.
- `c0_rsp_valid`  in  1  read response strobe.
- `c0_rsp_mdata`  in  16  response tag.
- `c0_rsp_data`  in  512  response line.
- `c1_req_valid`  out  1  write request strobe.
- `c1_req_addr`  out  42  write address.
- `c1_req_sop`  out  1  always 1 whenever `c1_req_valid` is high.
- `c1_req_data`  out  512  write line.
- `c1_alm_full`  in  1  c1 TX almost-full.
- `c1_rsp_valid`  in  1  write ack.

## Operation
States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.

- **IDLE**
  - On `start`, latch `src_addr`, `dst_addr` and `num_lines`, clear `idx`, `lines_done` and `error`.
  - If `num_lines == 0`, pulse `done` next cycle and stay in IDLE.
  - Otherwise go to RD_REQ.
- **RD_REQ**
  - If `c0_alm_full == 0`, drive a one-cycle `c0_req_valid` with addr = `src_base + idx` (42-bit modulo, wraps silently) and mdata = `idx`, then go to RD_WAIT.
  - Otherwise hold in RD_REQ.
- **RD_WAIT**
  - Accept only `c0_rsp_valid && c0_rsp_mdata == idx`; a response with a mismatched tag is ignored.
  - On accept, register `c1_req_data` = `{503'b0, sum[8:0]}`, where sum = `data[OPA_LSB+:8] + data[OPB_LSB+:8]` as an unsigned 9-bit add with no truncation. Go to WR_REQ.
- **WR_REQ**
  - Same almost-full rule on `c1_alm_full`: one-cycle `c1_req_valid` with `c1_req_sop` = 1 and addr = `dst_base + idx`, then go to WR_WAIT.
- **WR_WAIT**
  - On `c1_rsp_valid`, increment `lines_done`.
  - If `idx + 1 == num_lines`, pulse `done` and go to IDLE.
  - Otherwise increment `idx` and go to RD_REQ.
- Only one request is outstanding at any time.
- `start` while busy is ignored. It does not re-sample any input.
- Reset mid-job returns to IDLE with all outputs at reset values. A response arriving after reset is ignored.

## Timing
- Reset values: `busy`, `done`, `error`, `c0_req_valid`, `c1_req_valid` and `c1_req_sop` are 0; `lines_done` is 0.
- Address and data outputs reset to 0. They are don't-care while their valid is low.
- All outputs are registered.
- Almost-full is sampled in cycle t; the request valid is asserted in t+1 for exactly one cycle.
- Start accepted at t: `busy` = 1 at t+1, first `c0_req_valid` at t+2 when `c0_alm_full` is low.
- Read response accepted at t: `c1_req_valid` at t+2 when `c1_alm_full` is low.
- Write ack at t:
  - `lines_done` updates at t+1.
  - For the last line, `done` = 1 and `busy` = 0 at t+1.
  - Otherwise the next `c0_req_valid` is at t+2.
- Minimum per line: 4 cycles plus the two round-trip latencies.
- `c0_rsp_valid` and `c1_rsp_valid` in the same cycle: each is evaluated against the current state only. An event that does not match the current state is ignored.

## Configuration
- `ADD_NUM_SEQ_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to RD_WAIT or WR_WAIT and counts while in either state.
  - When it reaches `TIMEOUT_CYCLES`, set `error` = 1, pulse `done`, deassert `busy`, go to IDLE. `lines_done` holds its value.
- Undefined: no counter; the sequencer waits indefinitely and `error` is tied to 0.

## Test plan
- `num_lines` = 1, src line with byte1 = 0x12 and byte2 = 0x34, both channels free → one read and one write to dst; write data = 0x046; `done` pulse; `lines_done` = 1.
- Operands 0xFF + 0xFF → write data bits [8:0] = 0x1FE, all other bits 0.
- `num_lines` = 3, `src_addr` = 0x3FF_FFFF_FFFF → read addresses 0x3FF_FFFF_FFFF, 0x0, 0x1 (wrap); three writes; `lines_done` = 3.
- `c0_alm_full` held high for 10 cycles in RD_REQ → no `c0_req_valid` during those cycles; request issued 1 cycle after release; a stray response with mdata = 5 injected in RD_WAIT is ignored.
- `start` = 1 while busy, and `num_lines` = 0 → busy-time start changes nothing; zero count gives `done` the cycle after start with no requests issued.
- With macro, `TIMEOUT_CYCLES` = 16, no read response → `error` = 1 and `done` 16 cycles after entering RD_WAIT; the next start clears `error`. Reset asserted in WR_WAIT → all outputs at reset values next cycle.

Source files
------------

// File: rtl/add_num_seq_if.sv
// CCI-P c0 (read) and c1 (write) channel bundle between the add-numbers
// sequencer (master) and the host channel mux (slave).
interface add_num_seq_if;
    localparam int unsigned ADDR_W = 42;
    localparam int unsigned TAG_W  = 16;
    localparam int unsigned LINE_W = 512;

    logic              c0_req_valid;
    logic [ADDR_W-1:0] c0_req_addr;
    logic [TAG_W-1:0]  c0_req_mdata;
    logic              c0_alm_full;
    logic              c0_rsp_valid;
    logic [TAG_W-1:0]  c0_rsp_mdata;
    logic [LINE_W-1:0] c0_rsp_data;

    logic              c1_req_valid;
    logic [ADDR_W-1:0] c1_req_addr;
    logic              c1_req_sop;
    logic [LINE_W-1:0] c1_req_data;
    logic              c1_alm_full;
    logic              c1_rsp_valid;

    modport master (
        output c0_req_valid, c0_req_addr, c0_req_mdata,
        input  c0_alm_full, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        output c1_req_valid, c1_req_addr, c1_req_sop, c1_req_data,
        input  c1_alm_full, c1_rsp_valid
    );

    modport slave (
        input  c0_req_valid, c0_req_addr, c0_req_mdata,
        output c0_alm_full, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        input  c1_req_valid, c1_req_addr, c1_req_sop, c1_req_data,
        output c1_alm_full, c1_rsp_valid
    );
endinterface

// File: rtl/add_num_seq.sv
// Add-numbers AFU sequencer: per line, one c0 read, add two bytes of the
// returned line, one c1 write of the 9-bit sum, wait for the ack.
// Optional response timeout enabled by defining ADD_NUM_SEQ_TIMEOUT_EN.
module add_num_seq #(
    parameter int unsigned OPA_LSB        = 8,
    parameter int unsigned OPB_LSB        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [41:0]   src_addr,
    input  logic [41:0]   dst_addr,
    input  logic [15:0]   num_lines,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   lines_done,
    add_num_seq_if.master bus
);
    localparam int unsigned ADDR_W = 42;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned SUM_W  = 9;
    localparam int unsigned TMR_W  = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d;
    logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
    logic [CNT_W-1:0]    num_lines_q, num_lines_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    lines_done_q, lines_done_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                c0_req_valid_q, c0_req_valid_d;
    logic [ADDR_W-1:0]   c0_req_addr_q, c0_req_addr_d;
    logic [CNT_W-1:0]    c0_req_mdata_q, c0_req_mdata_d;
    logic                c1_req_valid_q, c1_req_valid_d;
    logic                c1_req_sop_q, c1_req_sop_d;
    logic [ADDR_W-1:0]   c1_req_addr_q, c1_req_addr_d;
    logic [LINE_W-1:0]   c1_req_data_q, c1_req_data_d;
    logic [SUM_W-1:0]    sum;
    logic                last_line;
`ifdef ADD_NUM_SEQ_TIMEOUT_EN
    logic [TMR_W-1:0]    timer_q, timer_d;
`else
    logic                unused_timeout_cfg;
    // Timeout limit has no effect in this build.
    assign unused_timeout_cfg = ^TMR_W'(TIMEOUT_CYCLES);
`endif

    // Next-state and next-value logic for every register.
    always_comb begin
        state_d        = state_q;
        src_base_d     = src_base_q;
        dst_base_d     = dst_base_q;
        num_lines_d    = num_lines_q;
        idx_d          = idx_q;
        lines_done_d   = lines_done_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        error_d        = error_q;
        c0_req_valid_d = 1'b0;
        c0_req_addr_d  = c0_req_addr_q;
        c0_req_mdata_d = c0_req_mdata_q;
        c1_req_valid_d = 1'b0;
        c1_req_sop_d   = 1'b0;
        c1_req_addr_d  = c1_req_addr_q;
        c1_req_data_d  = c1_req_data_q;
        sum            = SUM_W'(bus.c0_rsp_data[OPA_LSB +: OP_W])
                       + SUM_W'(bus.c0_rsp_data[OPB_LSB +: OP_W]);
        last_line      = (CNT_W'(idx_q + CNT_W'(1)) == num_lines_q);
`ifdef ADD_NUM_SEQ_TIMEOUT_EN
        timer_d        = timer_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_base_d   = src_addr;
                    dst_base_d   = dst_addr;
                    num_lines_d  = num_lines;
                    idx_d        = '0;
                    lines_done_d = '0;
                    error_d      = 1'b0;
                    if (num_lines == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (!bus.c0_alm_full) begin
                    c0_req_valid_d = 1'b1;
                    c0_req_addr_d  = src_base_q + ADDR_W'(idx_q);
                    c0_req_mdata_d = idx_q;
                    state_d        = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Responses carrying another line's tag are dropped.
                if (bus.c0_rsp_valid && (bus.c0_rsp_mdata == idx_q)) begin
                    c1_req_data_d = LINE_W'(sum);
                    state_d       = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!bus.c1_alm_full) begin
                    c1_req_valid_d = 1'b1;
                    c1_req_sop_d   = 1'b1;
                    c1_req_addr_d  = dst_base_q + ADDR_W'(idx_q);
                    state_d        = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (bus.c1_rsp_valid) begin
                    lines_done_d = CNT_W'(lines_done_q + CNT_W'(1));
                    if (last_line) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = CNT_W'(idx_q + CNT_W'(1));
                        state_d = RD_REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

`ifdef ADD_NUM_SEQ_TIMEOUT_EN
        // Timer is zero on entry to a wait state and aborts the job on expiry.
        if (((state_q == RD_WAIT) || (state_q == WR_WAIT)) && (state_d == state_q)) begin
            if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                error_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                timer_d = '0;
            end else begin
                timer_d = TMR_W'(timer_q + TMR_W'(1));
            end
        end else begin
            timer_d = '0;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job context and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_base_q     <= '0;
            dst_base_q     <= '0;
            num_lines_q    <= '0;
            idx_q          <= '0;
            lines_done_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            c0_req_valid_q <= 1'b0;
            c0_req_addr_q  <= '0;
            c0_req_mdata_q <= '0;
            c1_req_valid_q <= 1'b0;
            c1_req_sop_q   <= 1'b0;
            c1_req_addr_q  <= '0;
            c1_req_data_q  <= '0;
`ifdef ADD_NUM_SEQ_TIMEOUT_EN
            timer_q        <= '0;
`endif
        end else begin
            src_base_q     <= src_base_d;
            dst_base_q     <= dst_base_d;
            num_lines_q    <= num_lines_d;
            idx_q          <= idx_d;
            lines_done_q   <= lines_done_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            c0_req_valid_q <= c0_req_valid_d;
            c0_req_addr_q  <= c0_req_addr_d;
            c0_req_mdata_q <= c0_req_mdata_d;
            c1_req_valid_q <= c1_req_valid_d;
            c1_req_sop_q   <= c1_req_sop_d;
            c1_req_addr_q  <= c1_req_addr_d;
            c1_req_data_q  <= c1_req_data_d;
`ifdef ADD_NUM_SEQ_TIMEOUT_EN
            timer_q        <= timer_d;
`endif
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign lines_done       = lines_done_q;
    assign bus.c0_req_valid = c0_req_valid_q;
    assign bus.c0_req_addr  = c0_req_addr_q;
    assign bus.c0_req_mdata = c0_req_mdata_q;
    assign bus.c1_req_valid = c1_req_valid_q;
    assign bus.c1_req_sop   = c1_req_sop_q;
    assign bus.c1_req_addr  = c1_req_addr_q;
    assign bus.c1_req_data  = c1_req_data_q;
endmodule

// File: tb/tb_add_num_seq.sv
// Directed bench for add_num_seq with a small host model on the CCI-P bus.
module tb_add_num_seq;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [41:0] src_addr;
    logic [41:0] dst_addr;
    logic [15:0] num_lines;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] lines_done;

    add_num_seq_if bus();

    add_num_seq #(.OPA_LSB(8), .OPB_LSB(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .num_lines(num_lines), .busy(busy), .done(done),
        .error(error), .lines_done(lines_done), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Host model controls and logs.
    int          rd_lat = 2;
    int          wr_lat = 2;
    bit          rd_auto = 1'b1;
    bit          wr_auto = 1'b1;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] rd_tag;
    logic [41:0] rd_addr;
    int          stray_seq = 0;
    int          stray_seen = 0;
    logic [15:0] stray_tag = 16'd5;
    logic [7:0]  op_a = 8'h00;
    logic [7:0]  op_b = 8'h00;
    logic [41:0]  rd_addr_q[$];
    logic [15:0]  rd_tag_q[$];
    logic [41:0]  wr_addr_q[$];
    logic [511:0] wr_data_q[$];
    logic         wr_sop_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source line: all-ones background, operand A depends on the address.
    function automatic logic [511:0] line_for(input logic [41:0] a);
        logic [511:0] l;
        l = '1;
        l[15:8]  = 8'(op_a + a[7:0]);
        l[23:16] = op_b;
        return l;
    endfunction

    // Host: logs requests, answers reads and writes after a fixed latency.
    initial begin
        bus.c0_rsp_valid = 1'b0;
        bus.c0_rsp_mdata = '0;
        bus.c0_rsp_data  = '0;
        bus.c1_rsp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.c0_rsp_valid = 1'b0;
            bus.c1_rsp_valid = 1'b0;
            if (rd_cnt != 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    bus.c0_rsp_valid = 1'b1;
                    bus.c0_rsp_mdata = rd_tag;
                    bus.c0_rsp_data  = line_for(rd_addr);
                end
            end
            if (wr_cnt != 0) begin
                wr_cnt--;
                if (wr_cnt == 0) bus.c1_rsp_valid = 1'b1;
            end
            if (bus.c0_req_valid === 1'b1) begin
                rd_addr_q.push_back(bus.c0_req_addr);
                rd_tag_q.push_back(bus.c0_req_mdata);
                if (rd_auto) begin
                    rd_cnt  = rd_lat;
                    rd_tag  = bus.c0_req_mdata;
                    rd_addr = bus.c0_req_addr;
                end
            end
            if (bus.c1_req_valid === 1'b1) begin
                wr_addr_q.push_back(bus.c1_req_addr);
                wr_data_q.push_back(bus.c1_req_data);
                wr_sop_q.push_back(bus.c1_req_sop);
                if (wr_auto) wr_cnt = wr_lat;
            end
            if (stray_seq != stray_seen) begin
                stray_seen = stray_seq;
                bus.c0_rsp_valid = 1'b1;
                bus.c0_rsp_mdata = stray_tag;
                bus.c0_rsp_data  = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_addr_q.delete();
        rd_tag_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_sop_q.delete();
    endtask

    task automatic launch(input logic [41:0] s, input logic [41:0] d, input logic [15:0] n);
        src_addr  = s;
        dst_addr  = d;
        num_lines = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; src_addr = '0; dst_addr = '0; num_lines = '0;
        bus.c0_alm_full = 1'b0;
        bus.c1_alm_full = 1'b0;
        repeat (3) tick();
        checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
        checks++; if ({bus.c0_req_valid, bus.c1_req_valid, bus.c1_req_sop} !== 3'b000) begin failures++; $display("FAIL reset_valids: got %b want 000", {bus.c0_req_valid, bus.c1_req_valid, bus.c1_req_sop}); end
        checks++; if (lines_done !== 16'd0) begin failures++; $display("FAIL reset_lines_done: got %0d want 0", lines_done); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit seen;
        clear_logs();
        op_a = 8'h12; op_b = 8'h34; rd_lat = 2; wr_lat = 2;
        launch(42'h100, 42'h800, 16'd1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        checks++; if ({bus.c0_req_valid, bus.c0_req_addr, bus.c0_req_mdata} !== {1'b1, 42'h100, 16'd0}) begin failures++; $display("FAIL single_rd_req: got v=%b a=%0h t=%0h want v=1 a=100 t=0", bus.c0_req_valid, bus.c0_req_addr, bus.c0_req_mdata); end
        wait_done(50, seen);
        checks++; if (!seen) begin failures++; $display("FAIL single_done: got no done want done"); end
        checks++; if ({busy, lines_done} !== {1'b0, 16'd1}) begin failures++; $display("FAIL single_end: got busy=%b lines=%0d want busy=0 lines=1", busy, lines_done); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse: got %b want 0", done); end
        checks++; if (wr_addr_q.size() != 1 || rd_addr_q.size() != 1) begin failures++; $display("FAIL single_count: got rd=%0d wr=%0d want 1 1", rd_addr_q.size(), wr_addr_q.size()); end
        else begin
            checks++; if (wr_addr_q[0] !== 42'h800 || wr_sop_q[0] !== 1'b1) begin failures++; $display("FAIL single_wr_addr: got a=%0h sop=%b want a=800 sop=1", wr_addr_q[0], wr_sop_q[0]); end
            checks++; if (wr_data_q[0] !== 512'h46) begin failures++; $display("FAIL single_wr_data: got %0h want 46", wr_data_q[0]); end
        end
    endtask

    task automatic test_overflow();
        bit seen;
        clear_logs();
        op_a = 8'hFF; op_b = 8'hFF;
        launch(42'h200, 42'h900, 16'd1);
        wait_done(50, seen);
        checks++; if (!seen || wr_data_q.size() != 1) begin failures++; $display("FAIL ovf_done: got seen=%b wr=%0d want 1 1", seen, wr_data_q.size()); end
        else begin
            checks++; if (wr_data_q[0] !== 512'h1FE) begin failures++; $display("FAIL ovf_data: got %0h want 1fe", wr_data_q[0]); end
        end
    endtask

    task automatic test_wrap();
        bit seen;
        logic [41:0]  exp_rd[3];
        logic [511:0] exp_wd[3];
        exp_rd[0] = 42'h3FF_FFFF_FFFF; exp_rd[1] = 42'h0; exp_rd[2] = 42'h1;
        exp_wd[0] = 512'h2F; exp_wd[1] = 512'h30; exp_wd[2] = 512'h31;
        clear_logs();
        op_a = 8'h10; op_b = 8'h20; rd_lat = 1; wr_lat = 3;
        launch(42'h3FF_FFFF_FFFF, 42'h10, 16'd3);
        wait_done(100, seen);
        checks++; if (!seen || lines_done !== 16'd3) begin failures++; $display("FAIL wrap_done: got seen=%b lines=%0d want 1 3", seen, lines_done); end
        checks++; if (rd_addr_q.size() != 3 || wr_addr_q.size() != 3) begin failures++; $display("FAIL wrap_count: got rd=%0d wr=%0d want 3 3", rd_addr_q.size(), wr_addr_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rd_addr_q[i] !== exp_rd[i] || rd_tag_q[i] !== 16'(i)) begin failures++; $display("FAIL wrap_rd%0d: got a=%0h t=%0d want a=%0h t=%0d", i, rd_addr_q[i], rd_tag_q[i], exp_rd[i], i); end
                checks++; if (wr_addr_q[i] !== 42'(42'h10 + i) || wr_data_q[i] !== exp_wd[i]) begin failures++; $display("FAIL wrap_wr%0d: got a=%0h d=%0h want a=%0h d=%0h", i, wr_addr_q[i], wr_data_q[i], 42'h10 + i, exp_wd[i]); end
            end
        end
    endtask

    task automatic test_alm_full();
        bit seen;
        int vcount;
        clear_logs();
        op_a = 8'h05; op_b = 8'h07; rd_lat = 6; wr_lat = 2;
        bus.c0_alm_full = 1'b1;
        bus.c1_alm_full = 1'b1;
        launch(42'h300, 42'hA00, 16'd1);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.c0_req_valid !== 1'b0) vcount++;
        end
        checks++; if (vcount != 0) begin failures++; $display("FAIL alm_c0_held: got %0d valid cycles want 0", vcount); end
        bus.c0_alm_full = 1'b0;
        tick();
        checks++; if (bus.c0_req_valid !== 1'b1) begin failures++; $display("FAIL alm_c0_release: got %b want 1", bus.c0_req_valid); end
        stray_tag = 16'd5;
        stray_seq++;
        repeat (14) tick();
        checks++; if (wr_addr_q.size() != 0 || bus.c1_req_valid !== 1'b0) begin failures++; $display("FAIL alm_c1_held: got %0d writes want 0", wr_addr_q.size()); end
        bus.c1_alm_full = 1'b0;
        tick();
        checks++; if (bus.c1_req_valid !== 1'b1) begin failures++; $display("FAIL alm_c1_release: got %b want 1", bus.c1_req_valid); end
        wait_done(50, seen);
        checks++; if (!seen || wr_data_q.size() != 1) begin failures++; $display("FAIL alm_done: got seen=%b wr=%0d want 1 1", seen, wr_data_q.size()); end
        else begin
            checks++; if (wr_data_q[0] !== 512'h0C) begin failures++; $display("FAIL alm_stray_ignored: got %0h want c", wr_data_q[0]); end
        end
    endtask

    task automatic test_busy_start();
        bit seen;
        int dcount;
        clear_logs();
        op_a = 8'h01; op_b = 8'h02; rd_lat = 2; wr_lat = 2;
        launch(42'h40, 42'h80, 16'd2);
        tick();
        launch(42'h999, 42'h777, 16'd1);
        wait_done(100, seen);
        checks++; if (!seen || lines_done !== 16'd2) begin failures++; $display("FAIL busy_done: got seen=%b lines=%0d want 1 2", seen, lines_done); end
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) dcount++;
        end
        checks++; if (dcount != 0) begin failures++; $display("FAIL busy_no_rerun: got %0d active cycles want 0", dcount); end
        checks++; if (rd_addr_q.size() != 2 || wr_addr_q.size() != 2) begin failures++; $display("FAIL busy_count: got rd=%0d wr=%0d want 2 2", rd_addr_q.size(), wr_addr_q.size()); end
        else begin
            checks++; if (rd_addr_q[1] !== 42'h41 || wr_addr_q[1] !== 42'h81 || wr_data_q[1] !== 512'h44) begin failures++; $display("FAIL busy_line1: got ra=%0h wa=%0h d=%0h want 41 81 44", rd_addr_q[1], wr_addr_q[1], wr_data_q[1]); end
        end
        clear_logs();
        launch(42'h50, 42'h90, 16'd0);
        checks++; if ({done, lines_done} !== {1'b1, 16'd0}) begin failures++; $display("FAIL zero_done: got done=%b lines=%0d want 1 0", done, lines_done); end
        repeat (4) tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || rd_addr_q.size() != 0) begin failures++; $display("FAIL zero_idle: got done=%b busy=%b reads=%0d want 0 0 0", done, busy, rd_addr_q.size()); end
    endtask

    task automatic test_timeout();
        bit seen;
        int cyc;
        clear_logs();
        rd_auto = 1'b0;
        launch(42'h600, 42'hB00, 16'd1);
        tick();
        checks++; if (bus.c0_req_valid !== 1'b1) begin failures++; $display("FAIL to_rd_req: got %b want 1", bus.c0_req_valid); end
`ifdef ADD_NUM_SEQ_TIMEOUT_EN
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        checks++; if (cyc != 16) begin failures++; $display("FAIL to_latency: got %0d want 16", cyc); end
        checks++; if ({error, busy, lines_done} !== {1'b1, 1'b0, 16'd0}) begin failures++; $display("FAIL to_flags: got err=%b busy=%b lines=%0d want 1 0 0", error, busy, lines_done); end
        rd_auto = 1'b1;
        op_a = 8'h00; op_b = 8'h00;
        launch(42'h700, 42'hC00, 16'd1);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL to_error_clear: got %b want 0", error); end
        wait_done(60, seen);
        checks++; if (!seen || lines_done !== 16'd1) begin failures++; $display("FAIL to_rerun: got seen=%b lines=%0d want 1 1", seen, lines_done); end
`else
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0) cyc++;
        end
        checks++; if ({cyc != 0, busy, error} !== 3'b010) begin failures++; $display("FAIL wait_forever: got done_cycles=%0d busy=%b err=%b want 0 1 0", cyc, busy, error); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rd_auto = 1'b1;
        tick();
        seen = 1'b0;
`endif
        rd_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit found;
        int dcount;
        clear_logs();
        op_a = 8'h11; op_b = 8'h22; rd_lat = 1; wr_lat = 4;
        launch(42'h123, 42'h500, 16'd2);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.c1_req_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL rst_reach_wr: got no write want write"); end
        reset_n = 1'b0;
        tick();
        checks++; if ({busy, done, error, bus.c0_req_valid, bus.c1_req_valid, bus.c1_req_sop} !== 6'b0) begin failures++; $display("FAIL rst_mid_flags: got %b want 000000", {busy, done, error, bus.c0_req_valid, bus.c1_req_valid, bus.c1_req_sop}); end
        checks++; if ({lines_done, bus.c0_req_addr, bus.c0_req_mdata, bus.c1_req_addr} !== '0 || bus.c1_req_data !== '0) begin failures++; $display("FAIL rst_mid_data: got lines=%0d ra=%0h t=%0h wa=%0h d=%0h want all 0", lines_done, bus.c0_req_addr, bus.c0_req_mdata, bus.c1_req_addr, bus.c1_req_data); end
        reset_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || bus.c0_req_valid !== 1'b0) dcount++;
        end
        checks++; if (dcount != 0 || lines_done !== 16'd0) begin failures++; $display("FAIL rst_late_ack: got active=%0d lines=%0d want 0 0", dcount, lines_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_wrap();
        test_alm_full();
        test_busy_start();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
